// File: rtl/clahe_video_pkg.sv
// ---------------------------------------------------------------------------
// clahe_video_pkg
//  Shared definitions for the CLAHE video-stream blocks.
//  - Default data/dimension/FIFO sizes.
//  - FSM state encoding of the raster-to-AXIS bridge (also exported as debug).
//  - FIFO entry layout: {tuser, tlast, data}, i.e. TAG_W tag bits above the
//    pixel; the tuser bit is the MSB and tlast sits directly above the data.
// ---------------------------------------------------------------------------
package clahe_video_pkg;

   localparam int DATA_W_DEF     = 8;
   localparam int DIM_W_DEF      = 11;
   localparam int FIFO_DEPTH_DEF = 16;

   // Number of tag bits stored in each FIFO entry above the pixel data.
   localparam int TAG_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2,
      ST_RESYNC = 2'd3
   } state_e;

endpackage

// File: rtl/clahe_raster_to_axis_if.sv
// ---------------------------------------------------------------------------
// clahe_raster_to_axis_if
//  AXI4-Stream link carrying pixels with start-of-frame (tuser) and
//  end-of-line (tlast) markers.
//  Handshake: a beat transfers on a clock edge where tvalid & tready are both
//  1. While tvalid=1 and tready=0 the master holds tdata/tuser/tlast and keeps
//  tvalid asserted. tvalid never depends combinationally on tready.
//  Modports: master (drives tdata/tvalid/tuser/tlast, reads tready),
//            slave  (the reverse).
// ---------------------------------------------------------------------------
interface clahe_raster_to_axis_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tuser;
   logic              tlast;

   modport master (output tdata, tvalid, tuser, tlast, input tready);
   modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/clahe_fwft_fifo.sv
// ---------------------------------------------------------------------------
// clahe_fwft_fifo
//  First-word-fall-through FIFO with a registered head entry.
//  Ports:
//   clk, rst  clock / asynchronous active-high reset
//   push, din write request and data (ignored when full unless popping)
//   pop       consume the head entry (ignored when empty)
//   full      DEPTH entries stored
//   empty     registered; head is valid when empty=0
//   head      registered head entry, stable until popped
//  Pointers carry one extra wrap bit to tell full from empty.
// ---------------------------------------------------------------------------
module clahe_fwft_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic             head_v;
   logic             push_ok, pop_ok;

   assign pop_ok   = pop & head_v;
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push_ok  = push & (~full | pop_ok);
   assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push_ok};
   assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop_ok};
   assign empty    = ~head_v;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head_v <= 1'b0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         head_v <= (wr_ptr_n != rd_ptr_n);
         // Reload the head from the next read slot; bypass din when that slot
         // is the one being written this cycle (FIFO ends up holding only it).
         if (wr_ptr_n != rd_ptr_n) begin
            if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) head <= din;
            else                                                 head <= mem[rd_ptr_n[AW-1:0]];
         end
      end
   end
endmodule

// File: rtl/clahe_raster_to_axis.sv
// ---------------------------------------------------------------------------
// clahe_raster_to_axis
//  Converts the equalizer raster output (v_sync/data_en/pixel) into an
//  AXI4-Stream master with tuser = start of frame and tlast = end of line.
//  The raster side cannot stall, so a FIFO absorbs TREADY backpressure; a
//  push into a full FIFO drops the pixel, sets the sticky overflow flag and
//  discards everything until the next frame start.
//  Ports:
//   clk, rst        clock / asynchronous active-high reset
//   width, height   frame size, sampled on the v_sync rising edge
//   h_sync          accepted for interface symmetry, not used for framing
//   v_sync          1 = frame active, rising edge = new frame
//   data_en, pixel  one pixel per cycle when data_en=1
//   m               AXI4-Stream master
//   frame_done      1-cycle pulse as the frame's last pixel enters the FIFO
//   overflow        sticky FIFO overflow flag
//   fsm_state       current FSM state (debug)
//  Latency with an empty FIFO: data_en at cycle N -> FIFO write at N+1 ->
//  m.tvalid at N+2.
// ---------------------------------------------------------------------------
module clahe_raster_to_axis
   import clahe_video_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int DIM_W      = DIM_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIM_W-1:0]    width,
   input  logic [DIM_W-1:0]    height,
   input  logic                h_sync,
   input  logic                v_sync,
   input  logic                data_en,
   input  logic [DATA_W-1:0]   pixel,
   clahe_raster_to_axis_if.master m,
   output logic                frame_done,
   output logic                overflow,
   output state_e              fsm_state
);
   localparam int EW = DATA_W + TAG_W;

   state_e           state_n, launch_state;
   logic             v_sync_q, rise, fall, start, dims_ok, frame_on, push_req;
   logic             tag_user, tag_last, last_px, drop, pop;
   logic [DIM_W-1:0] w_m1, h_m1, col, row;
   logic [DIM_W-1:0] cur_w_m1, cur_h_m1, cur_col, cur_row;
   logic             in_v;
   logic [EW-1:0]    in_entry, head;
   logic             fifo_full, fifo_empty;
   logic             h_sync_unused;

   assign h_sync_unused = h_sync;

   assign rise    = v_sync & ~v_sync_q;
   assign fall    = ~v_sync & v_sync_q;
   assign start   = rise && (fsm_state != ST_ACTIVE);
   assign dims_ok = (width != '0) && (height != '0);

   // On the frame-start cycle the pixel belongs to the new frame, so use the
   // freshly presented dimensions and zeroed counters instead of the latches.
   assign cur_w_m1 = start ? width  - DIM_W'(1) : w_m1;
   assign cur_h_m1 = start ? height - DIM_W'(1) : h_m1;
   assign cur_col  = start ? '0 : col;
   assign cur_row  = start ? '0 : row;

   assign frame_on = (fsm_state == ST_ACTIVE) || (start && dims_ok);
   assign push_req = frame_on & data_en;
   assign tag_user = (cur_col == '0) && (cur_row == '0);
   assign tag_last = (cur_col == cur_w_m1);
   assign last_px  = tag_last && (cur_row == cur_h_m1);

   assign pop  = ~fifo_empty & m.tready;
   // The input register's pixel finds the FIFO full with no pop to free a slot.
   assign drop = in_v & fifo_full & ~pop;

   assign launch_state = !dims_ok                ? ST_IDLE :
                         (push_req && last_px)   ? ST_DONE : ST_ACTIVE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_state <= ST_IDLE;
      else     fsm_state <= state_n;
   end

   always_comb begin
      state_n = fsm_state;
      case (fsm_state)
         ST_ACTIVE: begin
            if (fall)                       state_n = ST_IDLE;
            else if (push_req && last_px)   state_n = ST_DONE;
         end
         ST_DONE: begin
            if (fall)       state_n = ST_IDLE;
            else if (start) state_n = launch_state;
         end
         default: begin
            if (start) state_n = launch_state;
         end
      endcase
      if (drop) state_n = ST_RESYNC;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_sync_q   <= 1'b0;
         w_m1       <= '0;
         h_m1       <= '0;
         col        <= '0;
         row        <= '0;
         in_v       <= 1'b0;
         in_entry   <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         v_sync_q <= v_sync;
         if (start) begin
            w_m1 <= width  - DIM_W'(1);
            h_m1 <= height - DIM_W'(1);
         end
         if (push_req) begin
            if (tag_last) begin
               col <= '0;
               row <= cur_row + DIM_W'(1);
            end else begin
               col <= cur_col + DIM_W'(1);
               row <= cur_row;
            end
         end else if (start) begin
            col <= '0;
            row <= '0;
         end
         // A drop also squashes the pixel accepted in the same cycle.
         in_v       <= push_req & ~drop;
         in_entry   <= {tag_user, tag_last, pixel};
         frame_done <= push_req & last_px & ~drop;
         overflow   <= overflow | drop;
      end
   end

   clahe_fwft_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_v),
      .din   (in_entry),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   assign m.tvalid = ~fifo_empty;
   assign m.tuser  = head[EW-1];
   assign m.tlast  = head[EW-2];
   assign m.tdata  = head[DATA_W-1:0];
endmodule

// File: tb/tb_clahe_raster_to_axis.sv
module tb_clahe_raster_to_axis;
   import clahe_video_pkg::*;

   localparam int DATA_W = 8;
   localparam int DIM_W  = 11;
   localparam int DEPTH  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DIM_W-1:0]  width = '0, height = '0;
   logic              h_sync = 1'b0, v_sync = 1'b0, data_en = 1'b0;
   logic [DATA_W-1:0] pixel = '0;
   logic              frame_done, overflow;
   state_e            fsm_state;

   clahe_raster_to_axis_if #(.DATA_W(DATA_W)) m_if ();

   clahe_raster_to_axis #(
      .DATA_W     (DATA_W),
      .DIM_W      (DIM_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .width      (width),
      .height     (height),
      .h_sync     (h_sync),
      .v_sync     (v_sync),
      .data_en    (data_en),
      .pixel      (pixel),
      .m          (m_if.master),
      .frame_done (frame_done),
      .overflow   (overflow),
      .fsm_state  (fsm_state)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [DATA_W+1:0] exp_q[$];
   int cyc = 0;
   int en_cyc = 0;
   int sof_cyc = 0;
   int fd_count = 0;
   int fd0 = 0;
   logic prev_stall = 1'b0;
   logic [DATA_W+1:0] prev_beat = '0;
   logic [DATA_W+1:0] beat;
   logic [DATA_W+1:0] exp_beat;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         beat = {m_if.tuser, m_if.tlast, m_if.tdata};
         if (frame_done) fd_count++;
         if (prev_stall) begin
            check("hold_valid", {31'b0, m_if.tvalid}, 32'd1);
            check("hold_data", beat, prev_beat);
         end
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", beat, 32'hFFFF_FFFF);
            end else begin
               exp_beat = exp_q.pop_front();
               check("beat", beat, exp_beat);
            end
            if (m_if.tuser) sof_cyc = cyc;
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_beat  = beat;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raises v_sync with the first pixel on the same cycle, drives npix pixels
   // (base+i) with up to 'gap' idle cycles between them, then drops v_sync.
   // The first nexp pixels are expected on the stream, tagged from w.
   task automatic send_frame(input int w, input int h, input int npix,
                             input int nexp, input int base, input int gap);
      int n;
      step(1);
      width  = DIM_W'(w);
      height = DIM_W'(h);
      v_sync = 1'b1;
      for (int i = 0; i < npix; i++) begin
         data_en = 1'b1;
         h_sync  = 1'b1;
         pixel   = DATA_W'(base + i);
         if (i == 0) en_cyc = cyc;
         if (i < nexp) exp_q.push_back({(i == 0), ((i % w) == (w - 1)), pixel});
         step(1);
         data_en = 1'b0;
         h_sync  = 1'b0;
         n = (gap > 0) ? $urandom_range(0, gap) : 0;
         step(n);
      end
      step(2);
      v_sync = 1'b0;
      step(2);
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (exp_q.size() == 0) break;
         step(1);
      end
      check("drain", exp_q.size(), 0);
      exp_q.delete();
      step(2);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      m_if.tready = 1'b1;
      step(3);
      @(negedge clk);
      check("rst_tvalid", {31'b0, m_if.tvalid}, 0);
      check("rst_tdata", {24'b0, m_if.tdata}, 0);
      check("rst_tuser", {31'b0, m_if.tuser}, 0);
      check("rst_tlast", {31'b0, m_if.tlast}, 0);
      check("rst_frame_done", {31'b0, frame_done}, 0);
      check("rst_overflow", {31'b0, overflow}, 0);
      check("rst_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});
      step(1);
      rst = 1'b0;
      step(2);

      // 1: basic 4x2 frame, latency and frame_done
      fd0 = fd_count;
      send_frame(4, 2, 8, 8, 0, 0);
      wait_drain(40);
      check("t1_latency", sof_cyc - en_cyc, 2);
      check("t1_frame_done", fd_count - fd0, 1);
      check("t1_state_idle", {30'b0, fsm_state}, {30'b0, ST_IDLE});

      // 1b: pixels beyond the frame are dropped in DONE
      fd0 = fd_count;
      send_frame(4, 1, 6, 4, 8'h20, 0);
      wait_drain(40);
      check("t1b_frame_done", fd_count - fd0, 1);

      // 2: stall mid-frame for 6 cycles
      fork
         send_frame(4, 2, 8, 8, 8'h10, 1);
         begin
            step(4);
            m_if.tready = 1'b0;
            step(6);
            m_if.tready = 1'b1;
         end
      join
      wait_drain(60);
      check("t2_overflow", {31'b0, overflow}, 0);

      // 2b: random backpressure and random input gaps on an 8x3 frame
      fork
         send_frame(8, 3, 24, 24, 8'h40, 2);
         begin
            for (int i = 0; i < 60; i++) begin
               m_if.tready = ($urandom_range(0, 3) != 0);
               step(1);
            end
            m_if.tready = 1'b1;
         end
      join
      wait_drain(100);
      check("t2b_overflow", {31'b0, overflow}, 0);

      // 4: v_sync drops after 5 of 8 pixels, then a full frame
      send_frame(4, 2, 5, 5, 8'h60, 0);
      send_frame(4, 2, 8, 8, 8'h70, 0);
      wait_drain(60);

      // 6: zero width / zero height frames are ignored
      fd0 = fd_count;
      send_frame(0, 2, 8, 0, 8'h80, 0);
      check("t6_w0_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});
      send_frame(4, 0, 4, 0, 8'h90, 0);
      step(4);
      check("t6_no_done", fd_count - fd0, 0);
      check("t6_no_valid", {31'b0, m_if.tvalid}, 0);

      // 3: overflow with tready held low
      m_if.tready = 1'b0;
      send_frame(32, 1, 32, DEPTH, 8'hA0, 0);
      check("t3_overflow", {31'b0, overflow}, 1);
      check("t3_state", {30'b0, fsm_state}, {30'b0, ST_RESYNC});
      check("t3_valid", {31'b0, m_if.tvalid}, 1);
      m_if.tready = 1'b1;
      wait_drain(60);
      check("t3_empty", {31'b0, m_if.tvalid}, 0);
      send_frame(4, 2, 8, 8, 8'hD0, 0);
      wait_drain(40);
      check("t3_sticky", {31'b0, overflow}, 1);

      // 5: asynchronous reset mid-frame with data queued
      m_if.tready = 1'b0;
      send_frame(4, 2, 5, 0, 8'hE0, 0);
      check("t5_pre_valid", {31'b0, m_if.tvalid}, 1);
      @(posedge clk);
      #3;
      rst     = 1'b1;
      v_sync  = 1'b0;
      data_en = 1'b0;
      #1;
      check("t5_async_valid", {31'b0, m_if.tvalid}, 0);
      check("t5_async_ovf", {31'b0, overflow}, 0);
      check("t5_async_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});
      exp_q.delete();
      step(2);
      rst = 1'b0;
      m_if.tready = 1'b1;
      step(3);
      check("t5_empty", {31'b0, m_if.tvalid}, 0);
      fd0 = fd_count;
      send_frame(4, 2, 8, 8, 8'hF0, 0);
      wait_drain(40);
      check("t5_frame_done", fd_count - fd0, 1);
      check("t5_overflow", {31'b0, overflow}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
